// File: rtl/register_2b.sv
// register_2b: clocked data register with change-detect status.
// Ports: CLK, RST_N (sync, active-low), in_dat -> out_dat, prev_dat, chg, chg_cnt.
module register_2b #(
    parameter int unsigned WIDTH     = 2,
    parameter logic [31:0] RESET_VAL = 32'd0,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] in_dat,
    output logic [WIDTH-1:0] out_dat,
    output logic [WIDTH-1:0] prev_dat,
    output logic             chg,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam logic [WIDTH-1:0] RST_V = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             chg_q, chg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             diff;

    always_comb begin
        diff   = (in_dat != out_q);
        out_d  = in_dat;
        prev_d = out_q;
        chg_d  = diff;
        cnt_d  = cnt_q;
        // Counter sticks at all-ones instead of wrapping.
        if (diff && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            out_q  <= RST_V;
            prev_q <= RST_V;
            chg_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            out_q  <= out_d;
            prev_q <= prev_d;
            chg_q  <= chg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_dat  = out_q;
    assign prev_dat = prev_q;
    assign chg      = chg_q;
    assign chg_cnt  = cnt_q;

endmodule

// File: tb/tb_register_2b.sv
// tb_register_2b: directed + random checks of register_2b against a model.
// Two instances share stimulus: default counter width and a 2-bit counter.
module tb_register_2b;

    logic       CLK;
    logic       RST_N;
    logic [1:0] in_dat;

    logic [1:0] out_a, prev_a, out_b, prev_b;
    logic       chg_a, chg_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: history-level view of the register.
    logic [1:0] m_out, m_prev;
    logic       m_chg;
    int         m_changes;

    register_2b #(.WIDTH(2), .RESET_VAL(32'd0), .CNT_W(8)) u_a (
        .CLK(CLK), .RST_N(RST_N), .in_dat(in_dat),
        .out_dat(out_a), .prev_dat(prev_a), .chg(chg_a), .chg_cnt(cnt_a)
    );

    register_2b #(.WIDTH(2), .RESET_VAL(32'd0), .CNT_W(2)) u_b (
        .CLK(CLK), .RST_N(RST_N), .in_dat(in_dat),
        .out_dat(out_b), .prev_dat(prev_b), .chg(chg_b), .chg_cnt(cnt_b)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".out_a"},  32'(out_a),  32'(m_out));
        chk({tag, ".prev_a"}, 32'(prev_a), 32'(m_prev));
        chk({tag, ".chg_a"},  32'(chg_a),  32'(m_chg));
        chk({tag, ".cnt_a"},  32'(cnt_a),  32'(sat(m_changes, 8)));
        chk({tag, ".out_b"},  32'(out_b),  32'(m_out));
        chk({tag, ".prev_b"}, 32'(prev_b), 32'(m_prev));
        chk({tag, ".chg_b"},  32'(chg_b),  32'(m_chg));
        chk({tag, ".cnt_b"},  32'(cnt_b),  32'(sat(m_changes, 2)));
    endtask

    task automatic model_edge(input logic rst_n, input logic [1:0] d);
        if (!rst_n) begin
            m_out     = 2'd0;
            m_prev    = 2'd0;
            m_chg     = 1'b0;
            m_changes = 0;
        end else begin
            m_chg  = (d != m_out);
            m_prev = m_out;
            m_out  = d;
            if (m_chg) m_changes++;
        end
    endtask

    // Called at a falling edge: drive, take one rising edge, check at next fall.
    task automatic step(input string tag, input logic r, input logic [1:0] d);
        RST_N  = r;
        in_dat = d;
        @(posedge CLK);
        model_edge(r, d);
        @(negedge CLK);
        chk_all(tag);
    endtask

    initial begin
        logic [1:0] seq [5];
        RST_N     = 1'b0;
        in_dat    = 2'd3;
        m_out     = 2'd0;
        m_prev    = 2'd0;
        m_chg     = 1'b0;
        m_changes = 0;
        @(negedge CLK);

        // Reset for two edges with in_dat=3.
        step("rst0", 1'b0, 2'd3);
        step("rst1", 1'b0, 2'd3);
        chk("rst.out_const", 32'(out_a), 32'd0);

        // Capture sequence.
        seq = '{2'd2, 2'd3, 2'd3, 2'd1, 2'd0};
        for (int i = 0; i < 5; i++) step("cap", 1'b1, seq[i]);
        chk("cap.cnt_final", 32'(cnt_a), 32'd4);

        // Hold constant 1 for 10 cycles.
        for (int i = 0; i < 10; i++) step("hold", 1'b1, 2'd1);
        chk("hold.chg_const", 32'(chg_a), 32'd0);

        // Mid-stream reset while toggling 1/2.
        for (int i = 0; i < 4; i++) step("tog", 1'b1, (i % 2) ? 2'd2 : 2'd1);
        step("mid_rst", 1'b0, 2'd1);
        chk("mid_rst.cnt_const", 32'(cnt_a), 32'd0);
        for (int i = 0; i < 4; i++) step("resume", 1'b1, (i % 2) ? 2'd1 : 2'd2);

        // Saturation of the 2-bit counter: reset then toggle 0/3.
        step("sat_rst", 1'b0, 2'd0);
        for (int i = 0; i < 6; i++) begin
            step("sat", 1'b1, (i % 2) ? 2'd0 : 2'd3);
            chk("sat.chg_const", 32'(chg_b), 32'd1);
        end
        chk("sat.cnt_b_const", 32'(cnt_b), 32'd3);

        // Reset pulse strictly between edges has no effect.
        in_dat = 2'd0;
        #3 RST_N = 1'b0;
        #3 RST_N = 1'b1;
        #1 chk_all("async_mid");
        @(negedge CLK);
        step("async_next", 1'b1, 2'd0);

        // Random stream with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 15) != 0),
                 2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/register_2b.md
Name: register_2b

Overview:
- Clocked data register; default width 2 bits. Captures `in_dat` on every rising edge of `CLK` and presents it on `out_dat`.
- Adds change-detect status: previous value, one-cycle change pulse and a saturating change counter.
- Used as a pipeline/holding stage for small control codes in the command-line interface datapath.

Parameters:
- WIDTH, 2, data width of `in_dat`/`out_dat`/`prev_dat`; legal range 1..32.
- RESET_VAL, 0, value loaded into `out_dat` and `prev_dat` during reset; truncated to WIDTH bits.
- CNT_W, 8, width of change counter `chg_cnt`; legal range 1..16.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset, synchronous and active-low.
- in_dat  input  WIDTH  data to capture.
- out_dat  output  WIDTH  registered data.
- prev_dat  output  WIDTH  value `out_dat` held before the most recent edge.
- chg  output  1  high for exactly one cycle after an edge at which the captured value differed from the prior `out_dat`.
- chg_cnt  output  CNT_W  saturating count of value changes since reset.

Behaviour:
- All outputs are registered; no combinational path from input to output. Only the rising edge of `CLK` is used.
- Reset: on a rising edge with RST_N=0:
  - out_dat <= RESET_VAL, prev_dat <= RESET_VAL.
  - chg <= 0, chg_cnt <= 0.
  - `in_dat` is ignored on that edge.
- Reset has priority over capture; an RST_N assertion in mid-stream takes effect at the next rising edge only.
- Before the first reset edge, outputs are undefined; no initial values are required.
- Normal edge (RST_N=1):
  - out_dat <= in_dat (latency 1 cycle).
  - prev_dat <= old out_dat.
  - chg <= (in_dat != old out_dat).
  - chg_cnt <= chg_cnt+1 when (in_dat != old out_dat) and chg_cnt is not all-ones; otherwise holds.
- Counter saturates at 2^CNT_W-1 and never wraps.
- Holding a constant `in_dat`: out_dat stable, chg=0 after the first cycle, counter frozen.
- First edge after reset release: compares `in_dat` against RESET_VAL. If they differ, chg=1 and chg_cnt=1.
- Any `in_dat` change between edges has no effect until the next edge. Glitches are not recorded.
- Inputs must meet setup/hold around the rising edge. Benches change stimulus away from the edge, e.g. on the falling edge.
- Width: all WIDTH bits captured independently; no arithmetic on data. The comparison is a full-width inequality.

Test Plan:
- Reset: RST_N=0 for 2 edges with in_dat=3 -> out_dat=0, prev_dat=0, chg=0, chg_cnt=0.
- Capture sequence, clock period 20 ns, in_dat changed on falling edges: release reset, then in_dat=2 → 3 → 3 → 1 → 0 →
  - out_dat = 2, 3, 3, 1, 0 one edge after each change.
  - prev_dat = 0, 2, 3, 3, 1.
  - chg = 1, 1, 0, 1, 1.
  - chg_cnt ends at 4.
- Hold: in_dat=1 for 10 cycles -> out_dat=1, chg=0 after the first cycle, chg_cnt constant.
- Mid-stream reset: while in_dat toggles 1/2 each cycle, drive RST_N=0 for one edge -> that edge gives out_dat=0, chg_cnt=0; capture resumes at the next edge.
- Saturation with CNT_W=2: toggle in_dat 0/3 for 6 edges -> chg_cnt goes 1, 2, 3, 3, 3, 3; chg stays 1 every cycle.
- Asynchronous check: pulse RST_N low between edges only -> no output change.
